// File: rtl/wordle_pkg.sv
// -----------------------------------------------------------------------------
// wordle_pkg
//
// Shared definitions for the Wordle board controller: board size defaults,
// letter and tile-colour encodings, the sequencer state type and the
// externally visible game_state encoding.
//
// Configuration macro: DUP_EXACT_EN (consumed by the files that import this
// package; nothing in here depends on it).
// -----------------------------------------------------------------------------
package wordle_pkg;

  localparam int ROWS_DEFAULT     = 6;
  localparam int COLS_DEFAULT     = 5;
  localparam int LETTER_W_DEFAULT = 5;

  // Letters A..Z are 0..25; everything above that is not a letter.
  localparam int NUM_LETTERS  = 26;
  localparam int LETTER_EMPTY = 31;

  localparam logic [1:0] COLOR_NONE   = 2'd0;
  localparam logic [1:0] COLOR_GRAY   = 2'd1;
  localparam logic [1:0] COLOR_YELLOW = 2'd2;
  localparam logic [1:0] COLOR_GREEN  = 2'd3;

  localparam logic [1:0] GS_PLAYING  = 2'd0;
  localparam logic [1:0] GS_CHECKING = 2'd1;
  localparam logic [1:0] GS_WON      = 2'd2;
  localparam logic [1:0] GS_LOST     = 2'd3;

  typedef enum logic [2:0] {
    S_PLAYING,
    S_CHK_GREEN,
    S_CHK_YELLOW,
    S_WON,
    S_LOST
  } state_t;

  // Both scoring passes look the same from outside: CHECKING.
  function automatic logic [1:0] game_state_of(input state_t s);
    case (s)
      S_CHK_GREEN,
      S_CHK_YELLOW: game_state_of = GS_CHECKING;
      S_WON:        game_state_of = GS_WON;
      S_LOST:       game_state_of = GS_LOST;
      default:      game_state_of = GS_PLAYING;
    endcase
  endfunction

endpackage

// File: rtl/wordle_guess_checker.sv
// -----------------------------------------------------------------------------
// wordle_guess_checker
//
// Scores one submitted guess against the secret, one column per cycle.
// Owns the scan index, the per-letter count bank and the colour decision;
// the caller owns the pass sequencing and the tile storage.
//
// Configuration macro: DUP_EXACT_EN
//   defined   : two passes (exact matches, then leftover-aware yellows) using
//               a bank of 26 3-bit counters.
//   undefined : single pass; yellow whenever the letter occurs anywhere in
//               the secret. phase_yellow is never asserted by the caller.
//
// Ports:
//   dclk, clr     clock / asynchronous active-high reset
//   start         pulse on the cycle a guess is accepted; rewinds the scan
//   phase_green   high while the exact-match pass runs
//   phase_yellow  high while the leftover pass runs
//   guess         letters of the row being scored, col0 in [LETTER_W-1:0]
//   secret        secret letters, same packing
//   wr_en         colour write strobe for this cycle
//   wr_col        column to write (the current scan index)
//   wr_color      colour to write
//   scan_last     current scan index is the last column
//   all_green     the guess equals the secret
// -----------------------------------------------------------------------------
module wordle_guess_checker
  import wordle_pkg::*;
#(
  parameter int COLS     = COLS_DEFAULT,
  parameter int LETTER_W = LETTER_W_DEFAULT
) (
  input  logic                     dclk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     phase_green,
  input  logic                     phase_yellow,
  input  logic [COLS*LETTER_W-1:0] guess,
  input  logic [COLS*LETTER_W-1:0] secret,
  output logic                     wr_en,
  output logic [2:0]               wr_col,
  output logic [1:0]               wr_color,
  output logic                     scan_last,
  output logic                     all_green
);

  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  logic [2:0]          scan_idx;
  logic [LETTER_W-1:0] g_arr [COLS];
  logic [LETTER_W-1:0] s_arr [COLS];
  logic [LETTER_W-1:0] g_let;
  logic [LETTER_W-1:0] s_let;
  logic                exact;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      g_arr[c] = guess[c*LETTER_W +: LETTER_W];
      s_arr[c] = secret[c*LETTER_W +: LETTER_W];
    end
  end

  assign g_let     = g_arr[scan_idx];
  assign s_let     = s_arr[scan_idx];
  assign exact     = (g_let == s_let);
  assign scan_last = (scan_idx == LAST_COL);
  assign wr_col    = scan_idx;
  assign all_green = (guess == secret);

  // The index wraps after the last column so the second pass starts at 0
  // without needing its own rewind.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      scan_idx <= '0;
    end else if (start) begin
      scan_idx <= '0;
    end else if (phase_green || phase_yellow) begin
      scan_idx <= scan_last ? 3'd0 : scan_idx + 3'd1;
    end
  end

`ifdef DUP_EXACT_EN

  localparam logic [LETTER_W-1:0] LETTER_LIMIT = LETTER_W'(NUM_LETTERS);

  // count[x] = secret occurrences of x not yet claimed by a green or yellow.
  logic [2:0] count [NUM_LETTERS];
  logic       g_ok;
  logic       s_ok;
  logic       g_avail;

  assign g_ok    = (g_let < LETTER_LIMIT);
  assign s_ok    = (s_let < LETTER_LIMIT);
  assign g_avail = g_ok && (count[g_let] != 3'd0);

  // Exact pass writes only greens; non-green cells keep colour 0 until the
  // leftover pass decides them. Green cells are skipped on the second pass.
  always_comb begin
    wr_en    = 1'b0;
    wr_color = COLOR_NONE;
    if (phase_green) begin
      if (exact) begin
        wr_en    = 1'b1;
        wr_color = COLOR_GREEN;
      end
    end else if (phase_yellow && !exact) begin
      wr_en    = 1'b1;
      wr_color = g_avail ? COLOR_YELLOW : COLOR_GRAY;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_LETTERS; i++) count[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < NUM_LETTERS; i++) count[i] <= '0;
    end else if (phase_green && !exact && s_ok) begin
      count[s_let] <= count[s_let] + 3'd1;
    end else if (phase_yellow && !exact && g_avail) begin
      count[g_let] <= count[g_let] - 3'd1;
    end
  end

`else

  logic in_secret;

  always_comb begin
    in_secret = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (s_arr[c] == g_let) in_secret = 1'b1;
    end
  end

  always_comb begin
    wr_en    = phase_green;
    wr_color = COLOR_GRAY;
    if (exact)          wr_color = COLOR_GREEN;
    else if (in_secret) wr_color = COLOR_YELLOW;
  end

`endif

endmodule

// File: rtl/wordle_board_ctrl.sv
// -----------------------------------------------------------------------------
// wordle_board_ctrl
//
// Game sequencer and tile store for the Wordle board (pixel-clock domain).
// Holds the ROWS x COLS grid of letters and tile colours, edits the active
// row from key events, hands full rows to wordle_guess_checker for scoring
// and serves a registered (row, col) read port to the renderer.
//
// Configuration macro: DUP_EXACT_EN selects two-pass duplicate-exact scoring
// (CHK_GREEN then CHK_YELLOW); when undefined scoring is a single CHK_GREEN
// pass.
//
// Ports:
//   dclk, clr        pixel clock / asynchronous active-high reset
//   new_game         pulse: load secret_word, clear the board, back to PLAYING
//   secret_word      secret letters, col0 in [LETTER_W-1:0]
//   key_valid        key event strobe
//   key_code         letter 0..25 (other codes ignored)
//   key_bksp         backspace qualifier
//   key_enter        enter qualifier (beats backspace, which beats letter)
//   key_ready        high only while PLAYING
//   rd_row, rd_col   renderer cell index
//   rd_letter        letter at the indexed cell, 1-cycle latency
//   rd_color         tile colour at the indexed cell, 1-cycle latency
//   cur_row          active guess row
//   cur_col          next entry column, 0..COLS
//   game_state       0 PLAYING, 1 CHECKING, 2 WON, 3 LOST
//   check_done       one-cycle pulse after a row finishes scoring
// -----------------------------------------------------------------------------
module wordle_board_ctrl
  import wordle_pkg::*;
#(
  parameter int ROWS     = ROWS_DEFAULT,
  parameter int COLS     = COLS_DEFAULT,
  parameter int LETTER_W = LETTER_W_DEFAULT
) (
  input  logic                     dclk,
  input  logic                     clr,
  input  logic                     new_game,
  input  logic [COLS*LETTER_W-1:0] secret_word,
  input  logic                     key_valid,
  input  logic [LETTER_W-1:0]      key_code,
  input  logic                     key_bksp,
  input  logic                     key_enter,
  output logic                     key_ready,
  input  logic [2:0]               rd_row,
  input  logic [2:0]               rd_col,
  output logic [LETTER_W-1:0]      rd_letter,
  output logic [1:0]               rd_color,
  output logic [2:0]               cur_row,
  output logic [2:0]               cur_col,
  output logic [1:0]               game_state,
  output logic                     check_done
);

  localparam logic [LETTER_W-1:0] EMPTY        = LETTER_W'(LETTER_EMPTY);
  localparam logic [LETTER_W-1:0] LETTER_LIMIT = LETTER_W'(NUM_LETTERS);
  localparam logic [2:0]          ROWS_L       = 3'(ROWS);
  localparam logic [2:0]          COLS_L       = 3'(COLS);
  localparam logic [2:0]          LAST_ROW     = 3'(ROWS - 1);

  state_t                   state;
  logic [COLS*LETTER_W-1:0] secret;
  logic [LETTER_W-1:0]      grid_letter [ROWS][COLS];
  logic [1:0]               grid_color  [ROWS][COLS];
  logic [COLS*LETTER_W-1:0] guess;

  logic       key_accept;
  logic       do_enter;
  logic       do_bksp;
  logic       do_letter;
  logic       chk_green;
  logic       chk_yellow;
  logic       chk_wr_en;
  logic [2:0] chk_wr_col;
  logic [1:0] chk_wr_color;
  logic       chk_scan_last;
  logic       chk_all_green;
  logic       row_end;

  // A key arriving together with new_game is dropped. An enter on a short
  // row still shadows any backspace/letter qualifier in the same event.
  assign key_accept = key_valid && (state == S_PLAYING) && !new_game;
  assign do_enter   = key_accept && key_enter && (cur_col == COLS_L);
  assign do_bksp    = key_accept && !key_enter && key_bksp && (cur_col != 3'd0);
  assign do_letter  = key_accept && !key_enter && !key_bksp
                      && (key_code < LETTER_LIMIT) && (cur_col < COLS_L);

  assign chk_green  = (state == S_CHK_GREEN);
  assign chk_yellow = (state == S_CHK_YELLOW);

`ifdef DUP_EXACT_EN
  assign row_end = chk_yellow && chk_scan_last;
`else
  assign row_end = chk_green && chk_scan_last;
`endif

  assign key_ready  = (state == S_PLAYING);
  assign game_state = game_state_of(state);

  // The active row is stable for the whole scoring window because keys are
  // refused outside PLAYING, so the checker can read it combinationally.
  always_comb begin
    guess = '0;
    for (int c = 0; c < COLS; c++) begin
      guess[c*LETTER_W +: LETTER_W] = grid_letter[cur_row][c];
    end
  end

  wordle_guess_checker #(
    .COLS     (COLS),
    .LETTER_W (LETTER_W)
  ) u_checker (
    .dclk         (dclk),
    .clr          (clr),
    .start        (do_enter),
    .phase_green  (chk_green),
    .phase_yellow (chk_yellow),
    .guess        (guess),
    .secret       (secret),
    .wr_en        (chk_wr_en),
    .wr_col       (chk_wr_col),
    .wr_color     (chk_wr_color),
    .scan_last    (chk_scan_last),
    .all_green    (chk_all_green)
  );

  // Sequencer. new_game overrides everything, including a scan that is about
  // to finish, so no check_done can escape from an aborted row.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state      <= S_PLAYING;
      cur_row    <= '0;
      cur_col    <= '0;
      check_done <= 1'b0;
      secret     <= '0;
    end else begin
      check_done <= 1'b0;
      if (new_game) begin
        state   <= S_PLAYING;
        cur_row <= '0;
        cur_col <= '0;
        secret  <= secret_word;
      end else if (row_end) begin
        check_done <= 1'b1;
        if (chk_all_green) begin
          state <= S_WON;
        end else if (cur_row == LAST_ROW) begin
          state <= S_LOST;
        end else begin
          state   <= S_PLAYING;
          cur_row <= cur_row + 3'd1;
          cur_col <= '0;
        end
      end else begin
        case (state)
          S_PLAYING: begin
            if (do_enter)       state   <= S_CHK_GREEN;
            else if (do_bksp)   cur_col <= cur_col - 3'd1;
            else if (do_letter) cur_col <= cur_col + 3'd1;
          end
          S_CHK_GREEN: begin
`ifdef DUP_EXACT_EN
            if (chk_scan_last) state <= S_CHK_YELLOW;
`endif
          end
          S_CHK_YELLOW, S_WON, S_LOST: begin
          end
          default: state <= S_PLAYING;
        endcase
      end
    end
  end

  // Tile store: whole-board clear on new_game, otherwise at most one letter
  // write (edit) and one colour write (scoring) per cycle; they never overlap
  // because editing and scoring live in different states.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          grid_letter[r][c] <= EMPTY;
          grid_color[r][c]  <= COLOR_NONE;
        end
      end
    end else if (new_game) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          grid_letter[r][c] <= EMPTY;
          grid_color[r][c]  <= COLOR_NONE;
        end
      end
    end else begin
      if (do_letter) grid_letter[cur_row][cur_col] <= key_code;
      if (do_bksp)   grid_letter[cur_row][cur_col - 3'd1] <= EMPTY;
      if (chk_wr_en) grid_color[cur_row][chk_wr_col] <= chk_wr_color;
    end
  end

  // Renderer port: coordinates outside the board read as an empty tile.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      rd_letter <= EMPTY;
      rd_color  <= COLOR_NONE;
    end else if ((rd_row < ROWS_L) && (rd_col < COLS_L)) begin
      rd_letter <= grid_letter[rd_row][rd_col];
      rd_color  <= grid_color[rd_row][rd_col];
    end else begin
      rd_letter <= EMPTY;
      rd_color  <= COLOR_NONE;
    end
  end

endmodule

// File: tb/tb_wordle_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wordle_board_ctrl
//
// Self-checking bench for wordle_board_ctrl. Keeps its own picture of the
// board (letters, colours, cursor, game state) and scores guesses with the
// plain Wordle rules. Honours DUP_EXACT_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wordle_board_ctrl;

  localparam int ROWS = 6;
  localparam int COLS = 5;
  localparam int LW   = 5;
`ifdef DUP_EXACT_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif
  // Edges from the edge that samples enter to the edge that raises check_done.
  localparam int SCORE_EDGES = DUP ? 2 * COLS : COLS;

  logic             dclk;
  logic             clr;
  logic             new_game;
  logic [COLS*LW-1:0] secret_word;
  logic             key_valid;
  logic [LW-1:0]    key_code;
  logic             key_bksp;
  logic             key_enter;
  logic             key_ready;
  logic [2:0]       rd_row;
  logic [2:0]       rd_col;
  logic [LW-1:0]    rd_letter;
  logic [1:0]       rd_color;
  logic [2:0]       cur_row;
  logic [2:0]       cur_col;
  logic [1:0]       game_state;
  logic             check_done;

  wordle_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .LETTER_W(LW)) dut (
    .dclk        (dclk),
    .clr         (clr),
    .new_game    (new_game),
    .secret_word (secret_word),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_bksp    (key_bksp),
    .key_enter   (key_enter),
    .key_ready   (key_ready),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_letter   (rd_letter),
    .rd_color    (rd_color),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .game_state  (game_state),
    .check_done  (check_done)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  int checks   = 0;
  int failures = 0;

  // Reference picture of the game.
  int m_letter [ROWS][COLS];
  int m_color  [ROWS][COLS];
  int m_secret [COLS];
  int m_row;
  int m_col;
  int m_gs;

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int code, input bit bk, input bit en);
    key_valid = v;
    key_code  = LW'(code);
    key_bksp  = bk;
    key_enter = en;
    tick();
    key_valid = 1'b0;
    key_bksp  = 1'b0;
    key_enter = 1'b0;
  endtask

  function automatic logic [COLS*LW-1:0] wordBits(input string w);
    logic [COLS*LW-1:0] b;
    b = '0;
    for (int i = 0; i < COLS; i++) b[i*LW +: LW] = LW'(int'(w[i]) - 65);
    return b;
  endfunction

  task automatic clearModel();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_letter[r][c] = 31;
        m_color[r][c]  = 0;
      end
    m_row = 0;
    m_col = 0;
    m_gs  = 0;
  endtask

  task automatic startGame(input logic [COLS*LW-1:0] w);
    secret_word = w;
    for (int i = 0; i < COLS; i++) m_secret[i] = int'(w[i*LW +: LW]);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    clearModel();
    checkOutput("ng_state", 32'(game_state), 0);
    checkOutput("ng_row", 32'(cur_row), 0);
    checkOutput("ng_col", 32'(cur_col), 0);
  endtask

  // Wordle scoring from the rules: greens first; a non-green letter is yellow
  // while the secret still has unclaimed copies of it (claimed by greens or by
  // earlier yellows), otherwise gray.
  task automatic scoreRow(input int r, output bit allg);
    int  g [COLS];
    bit  grn [COLS];
    int  avail;
    int  used;
    bit  anywhere;
    allg = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      g[c]   = m_letter[r][c];
      grn[c] = (g[c] == m_secret[c]);
      if (!grn[c]) allg = 1'b0;
    end
    for (int i = 0; i < COLS; i++) begin
      if (grn[i]) begin
        m_color[r][i] = 3;
      end else if (DUP) begin
        avail = 0;
        used  = 0;
        for (int j = 0; j < COLS; j++)
          if (!grn[j] && m_secret[j] == g[i]) avail++;
        for (int k = 0; k < i; k++)
          if (!grn[k] && g[k] == g[i] && m_color[r][k] == 2) used++;
        m_color[r][i] = (avail > used) ? 2 : 1;
      end else begin
        anywhere = 1'b0;
        for (int j = 0; j < COLS; j++)
          if (m_secret[j] == g[i]) anywhere = 1'b1;
        m_color[r][i] = anywhere ? 2 : 1;
      end
    end
  endtask

  task automatic pressKey(input int code, input bit bksp);
    applyStimulus(1'b1, code, bksp, 1'b0);
    if (m_gs == 0) begin
      if (bksp) begin
        if (m_col > 0) begin
          m_col--;
          m_letter[m_row][m_col] = 31;
        end
      end else if (code < 26 && m_col < COLS) begin
        m_letter[m_row][m_col] = code;
        m_col++;
      end
    end
    checkOutput("key_col", 32'(cur_col), m_col);
    checkOutput("key_gs", 32'(game_state), m_gs);
  endtask

  task automatic typeWord(input logic [COLS*LW-1:0] w);
    for (int i = 0; i < COLS; i++) pressKey(int'(w[i*LW +: LW]), 1'b0);
  endtask

  task automatic submitGuess(input string tag);
    bit scoring;
    bit allg;
    int n;
    scoring = (m_gs == 0) && (m_col == COLS);
    applyStimulus(1'b1, 0, 1'b0, 1'b1);
    if (scoring) begin
      checkOutput({tag, "_ready_low"}, 32'(key_ready), 0);
      checkOutput({tag, "_gs_checking"}, 32'(game_state), 1);
      n = 0;
      while (check_done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      checkOutput({tag, "_latency"}, n, SCORE_EDGES);
      scoreRow(m_row, allg);
      if (allg) m_gs = 2;
      else if (m_row == ROWS - 1) m_gs = 3;
      else begin
        m_row++;
        m_col = 0;
      end
      checkOutput({tag, "_gs"}, 32'(game_state), m_gs);
      checkOutput({tag, "_row"}, 32'(cur_row), m_row);
      checkOutput({tag, "_col"}, 32'(cur_col), m_col);
      checkOutput({tag, "_ready"}, 32'(key_ready), (m_gs == 0) ? 1 : 0);
      tick();
      checkOutput({tag, "_done_pulse"}, 32'(check_done), 0);
    end else begin
      checkOutput({tag, "_ign_gs"}, 32'(game_state), m_gs);
      checkOutput({tag, "_ign_col"}, 32'(cur_col), m_col);
      repeat (SCORE_EDGES + 1) tick();
      checkOutput({tag, "_ign_done"}, 32'(check_done), 0);
    end
  endtask

  task automatic checkBoard(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rd_row = 3'(r);
        rd_col = 3'(c);
        tick();
        checkOutput($sformatf("%s_let_%0d_%0d", tag, r, c), 32'(rd_letter), m_letter[r][c]);
        checkOutput($sformatf("%s_col_%0d_%0d", tag, r, c), 32'(rd_color), m_color[r][c]);
      end
  endtask

  // Direct colour check of one row against hand-derived values.
  task automatic checkRowColors(input string tag, input int r, input logic [2*COLS-1:0] exp);
    for (int c = 0; c < COLS; c++) begin
      rd_row = 3'(r);
      rd_col = 3'(c);
      tick();
      checkOutput($sformatf("%s_c%0d", tag, c), 32'(rd_color), 32'(exp[2*c +: 2]));
    end
  endtask

  function automatic logic [COLS*LW-1:0] randomWord();
    logic [COLS*LW-1:0] w;
    for (int i = 0; i < COLS; i++) w[i*LW +: LW] = LW'($urandom_range(0, 25));
    return w;
  endfunction

  logic [COLS*LW-1:0] sec;
  logic [COLS*LW-1:0] gw;
  logic [2*COLS-1:0]  exp_row;

  initial begin
    clr = 1'b1; new_game = 1'b0; secret_word = '0;
    key_valid = 1'b0; key_code = '0; key_bksp = 1'b0; key_enter = 1'b0;
    rd_row = '0; rd_col = '0;
    clearModel();
    repeat (3) @(posedge dclk);
    #1 clr = 1'b0;

    // Reset state and the whole read window, including off-board cells.
    checkOutput("rst_letter", 32'(rd_letter), 31);
    checkOutput("rst_color", 32'(rd_color), 0);
    checkOutput("rst_gs", 32'(game_state), 0);
    checkOutput("rst_ready", 32'(key_ready), 1);
    checkOutput("rst_row", 32'(cur_row), 0);
    checkOutput("rst_col", 32'(cur_col), 0);
    checkOutput("rst_done", 32'(check_done), 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r);
        rd_col = 3'(c);
        tick();
        checkOutput($sformatf("rst_let_%0d_%0d", r, c), 32'(rd_letter), 31);
        checkOutput($sformatf("rst_clr_%0d_%0d", r, c), 32'(rd_color), 0);
      end

    // Winning first guess, then keys are refused.
    $display("[TB] CRANE win");
    startGame(wordBits("CRANE"));
    typeWord(wordBits("CRANE"));
    submitGuess("crane");
    checkBoard("crane");
    pressKey(3, 1'b0);
    pressKey(0, 1'b1);
    checkOutput("won_ready", 32'(key_ready), 0);
    rd_row = 3'd0; rd_col = 3'd5; tick();
    checkOutput("oor_0_5", 32'(rd_letter), 31);
    rd_row = 3'd6; rd_col = 3'd0; tick();
    checkOutput("oor_6_0", 32'(rd_color), 0);

    // Duplicate handling.
    $display("[TB] ABBEY / BABES");
    startGame(wordBits("ABBEY"));
    typeWord(wordBits("BABES"));
    submitGuess("babes");
    exp_row = {2'd1, 2'd3, 2'd3, 2'd2, 2'd2};
    checkRowColors("babes", 0, exp_row);
    checkBoard("babes");

    $display("[TB] LLAMA / ALLEL");
    startGame(wordBits("LLAMA"));
    typeWord(wordBits("ALLEL"));
    submitGuess("allel");
    exp_row = DUP ? {2'd1, 2'd1, 2'd2, 2'd3, 2'd2} : {2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
    checkRowColors("allel", 0, exp_row);
    checkBoard("allel");

    // Editing edges on row 1.
    $display("[TB] editing edges");
    pressKey(0, 1'b1);
    pressKey(28, 1'b0);
    for (int i = 0; i < 4; i++) pressKey(i + 7, 1'b0);
    submitGuess("enter_col4");
    pressKey(11, 1'b0);
    pressKey(12, 1'b0);
    pressKey(0, 1'b1);
    pressKey(0, 1'b1);
    pressKey(20, 1'b0);
    pressKey(21, 1'b0);
    checkBoard("edit");

    // Random secret, random edits, six wrong guesses: LOST.
    $display("[TB] random game to LOST");
    sec = randomWord();
    startGame(sec);
    for (int g = 0; g < ROWS; g++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) pressKey(0, 1'b1);
        else pressKey(int'($urandom_range(0, 31)), 1'b0);
      end
      while (m_col > 0) pressKey(0, 1'b1);
      do gw = randomWord(); while (gw == sec);
      typeWord(gw);
      submitGuess($sformatf("rnd%0d", g));
    end
    checkOutput("lost_gs", 32'(game_state), 3);
    checkBoard("lost");

    // new_game mid-scan, with a key in the same cycle.
    $display("[TB] abort during scoring");
    sec = randomWord();
    startGame(sec);
    typeWord(sec);
    applyStimulus(1'b1, 0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("mid_gs", 32'(game_state), 1);
    sec = randomWord();
    secret_word = sec;
    for (int i = 0; i < COLS; i++) m_secret[i] = int'(sec[i*LW +: LW]);
    new_game = 1'b1;
    key_valid = 1'b1;
    key_code = LW'(4);
    tick();
    new_game = 1'b0;
    key_valid = 1'b0;
    clearModel();
    checkOutput("abort_gs", 32'(game_state), 0);
    checkOutput("abort_row", 32'(cur_row), 0);
    checkOutput("abort_col", 32'(cur_col), 0);
    checkOutput("abort_ready", 32'(key_ready), 1);
    checkOutput("abort_done", 32'(check_done), 0);
    for (int i = 0; i < 2 * COLS + 2; i++) begin
      tick();
      checkOutput($sformatf("abort_nodone%0d", i), 32'(check_done), 0);
    end
    checkBoard("abort");

    // New secret is in effect after the abort.
    typeWord(sec);
    submitGuess("after_abort");
    checkOutput("after_abort_won", 32'(game_state), 2);
    checkBoard("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
